// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score display block:
//   - score/BCD/display widths
//   - leader codes (same 01/10 encoding as the score_control "who" field)
//   - active-low 7-segment glyph constants, bit order {g,f,e,d,c,b,a}
//   - FSM state type
//   - one double-dabble iteration step on a {bcd, binary} shift vector
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int unsigned SCORE_W    = 9;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned DD_W       = BCD_W + SCORE_W;

  localparam logic [1:0] LEAD_TIE = 2'b00;
  localparam logic [1:0] LEAD_A   = 2'b01;
  localparam logic [1:0] LEAD_B   = 2'b10;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV_A,
    CONV_B,
    COMMIT
  } state_t;

  // One shift-add-3 iteration: correct every BCD nibble >= 5, then shift the
  // whole {bcd, binary} vector left by one.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    t = v;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (t[SCORE_W+4*d +: 4] >= 4'd5)
        t[SCORE_W+4*d +: 4] = t[SCORE_W+4*d +: 4] + 4'd3;
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Ports:
//   i_bcd   [3:0] BCD digit (codes 10..15 show blank)
//   i_blank       force all segments off
//   o_seg   [6:0] active-low segments
// -----------------------------------------------------------------------------
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
// Captures two 9-bit score totals on load, converts each to 3-digit BCD with
// a sequential double-dabble (9 cycles per score), then commits both scores
// and the leader code atomically. A free-running scan multiplexes the six
// digits onto a single active-low 7-segment output.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit is driven per scan step (2..2^20)
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   load          capture request (ignored unless idle)
//   total_scoreA  [8:0] binary total, player A
//   total_scoreB  [8:0] binary total, player B
//   busy          conversion in progress (18 cycles)
//   valid         one-cycle pulse when new display data is committed
//   leader  [1:0] 01 = A ahead, 10 = B ahead, 00 = tie
//   digit_sel [5:0] one-hot digit enable, bit5..3 = A hund..units,
//                 bit2..0 = B hund..units
//   seg     [6:0] active-low segments {g,f,e,d,c,b,a}
//
// Build option:
//   LEAD_ZERO_BLANK_EN  blank leading-zero hundreds/tens digits of each score
// -----------------------------------------------------------------------------
module score_display
  import score_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SCORE_W-1:0] total_scoreA,
  input  logic [SCORE_W-1:0] total_scoreB,
  output logic               busy,
  output logic               valid,
  output logic [1:0]         leader,
  output logic [5:0]         digit_sel,
  output logic [6:0]         seg
);

  localparam int unsigned     CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       ITER_LAST = 4'(SCORE_W - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [3:0]                 r_iter;
  logic                       w_last;
  logic [SCORE_W-1:0]         r_cap_a;
  logic [SCORE_W-1:0]         r_cap_b;
  logic [DD_W-1:0]            r_shift;
  logic [DD_W-1:0]            w_dd;
  logic [BCD_W-1:0]           r_conv_a;
  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [1:0]                 r_leader;

  logic [CNT_W-1:0]           r_scan_cnt;
  logic                       w_scan_wrap;
  logic [NUM_DIGITS-1:0]      r_digit_sel;
  logic [NUM_DIGITS-1:0]      w_sel_next;
  logic [6:0]                 r_seg;
  logic [3:0]                 w_dig;
  logic                       w_blank;
  logic [6:0]                 w_seg;

  assign w_dd   = dd_step(r_shift);
  assign w_last = (r_iter == ITER_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    valid        = 1'b0;
    case (r_state)
      IDLE:    if (load) w_state_next = CONV_A;
      CONV_A: begin
        busy = 1'b1;
        if (w_last) w_state_next = CONV_B;
      end
      CONV_B: begin
        busy = 1'b1;
        if (w_last) w_state_next = COMMIT;
      end
      COMMIT: begin
        valid        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- conversion datapath ----------------
  // Display registers load on the edge entering COMMIT, so the new digits
  // and leader are already presented while valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter   <= '0;
      r_cap_a  <= '0;
      r_cap_b  <= '0;
      r_shift  <= '0;
      r_conv_a <= '0;
      r_dig    <= '0;
      r_leader <= LEAD_TIE;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_cap_a <= total_scoreA;
            r_cap_b <= total_scoreB;
            r_shift <= {BCD_W'(0), total_scoreA};
            r_iter  <= '0;
          end
        end
        CONV_A: begin
          if (w_last) begin
            r_conv_a <= w_dd[DD_W-1:SCORE_W];
            r_shift  <= {BCD_W'(0), r_cap_b};
            r_iter   <= '0;
          end else begin
            r_shift <= w_dd;
            r_iter  <= r_iter + 4'd1;
          end
        end
        CONV_B: begin
          if (w_last) begin
            r_dig  <= {r_conv_a, w_dd[DD_W-1:SCORE_W]};
            r_iter <= '0;
            if (r_cap_a > r_cap_b)      r_leader <= LEAD_A;
            else if (r_cap_b > r_cap_a) r_leader <= LEAD_B;
            else                        r_leader <= LEAD_TIE;
          end else begin
            r_shift <= w_dd;
            r_iter  <= r_iter + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- display scan ----------------
  assign w_scan_wrap = (r_scan_cnt == CNT_MAX);
  assign w_sel_next  = w_scan_wrap ? {r_digit_sel[0], r_digit_sel[NUM_DIGITS-1:1]}
                                   : r_digit_sel;

  // seg is registered from the selection that digit_sel takes on the same
  // edge, so the two outputs always change together.
  always_comb begin
    w_dig   = '0;
    w_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel_next[i]) w_dig = r_dig[i];
    end
`ifdef LEAD_ZERO_BLANK_EN
    if (w_sel_next[5]) w_blank = (r_dig[5] == 4'd0);
    if (w_sel_next[4]) w_blank = (r_dig[5] == 4'd0) && (r_dig[4] == 4'd0);
    if (w_sel_next[2]) w_blank = (r_dig[2] == 4'd0);
    if (w_sel_next[1]) w_blank = (r_dig[2] == 4'd0) && (r_dig[1] == 4'd0);
`else
    w_blank = 1'b0;
`endif
  end

  seg7_decode u_seg7_decode (
    .i_bcd   (w_dig),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= 6'b100000;
      r_seg       <= SEG_0;
    end else begin
      r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_digit_sel <= w_sel_next;
      r_seg       <= w_seg;
    end
  end

  assign leader    = r_leader;
  assign digit_sel = r_digit_sel;
  assign seg       = r_seg;

endmodule

// File: tb/tb_score_display.sv
// -----------------------------------------------------------------------------
// tb_score_display
// Randomized and directed stimulus for score_display (SCAN_DIV = 4) checked
// against a behavioural model: decimal digits by divide/modulo, leader by
// compare, scan position from the count of clock edges since reset.
// -----------------------------------------------------------------------------
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [8:0] a_in;
  logic [8:0] b_in;
  logic       busy;
  logic       valid;
  logic [1:0] leader;
  logic [5:0] digit_sel;
  logic [6:0] seg;

  score_display #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .total_scoreA (a_in),
    .total_scoreB (b_in),
    .busy         (busy),
    .valid        (valid),
    .leader       (leader),
    .digit_sel    (digit_sel),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         k        = 0;   // clock edges since reset release
  int         disp[6];        // index = digit_sel bit position
  logic [1:0] exp_lead;
  logic [6:0] glyph[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] exp_seg(input int pos);
    int d;
    d = disp[pos];
`ifdef LEAD_ZERO_BLANK_EN
    if ((pos % 3) == 2 && d == 0) return 7'h7f;
    if ((pos % 3) == 1 && d == 0 && disp[pos+1] == 0) return 7'h7f;
`endif
    return glyph[d];
  endfunction

  task automatic set_model(input int a, input int b);
    disp[5] = a / 100; disp[4] = (a / 10) % 10; disp[3] = a % 10;
    disp[2] = b / 100; disp[1] = (b / 10) % 10; disp[0] = b % 10;
    exp_lead = (a > b) ? 2'b01 : (b > a) ? 2'b10 : 2'b00;
  endtask

  // One clock cycle; afterwards check scan position and segment pattern.
  task automatic cyc();
    int pos;
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    pos = 5 - ((k / 4) % 6);
    check("digit_sel", {26'd0, digit_sel}, 32'd1 << pos);
    if (rst) check("seg_in_reset", {25'd0, seg}, 32'h40);
    else     check("seg", {25'd0, seg}, {25'd0, exp_seg(pos)});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check("idle_valid", {31'd0, valid}, 0);
      check("idle_busy", {31'd0, busy}, 0);
    end
  endtask

  // glitch: busy cycle (2..18) in which a second load is raised, 0 = none
  task automatic convert(input int a, input int b, input int glitch);
    a_in = 9'(a); b_in = 9'(b); load = 1'b1;
    cyc();
    load = 1'b0;
    a_in = 9'($urandom_range(0, 511));
    b_in = 9'($urandom_range(0, 511));
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) cyc();
      check("busy", {31'd0, busy}, 1);
      check("valid_early", {31'd0, valid}, 0);
      check("leader_hold", {30'd0, leader}, {30'd0, exp_lead});
      load = (i == glitch);
    end
    cyc();
    load = 1'b0;
    check("valid", {31'd0, valid}, 1);
    check("busy_in_commit", {31'd0, busy}, 0);
    set_model(a, b);
    check("leader", {30'd0, leader}, {30'd0, exp_lead});
    idle_cycles(26);
  endtask

  task automatic reset_mid_conversion();
    a_in = 9'($urandom_range(0, 511)); b_in = 9'($urandom_range(0, 511));
    load = 1'b1;
    cyc();
    load = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    #1;
    k = 0;
    set_model(0, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_leader", {30'd0, leader}, 0);
    check("rst_sel", {26'd0, digit_sel}, 32'h20);
    check("rst_seg", {25'd0, seg}, 32'h40);
    cyc();
    cyc();
    rst = 1'b0;
    idle_cycles(30);
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; a_in = 9'd77; b_in = 9'd3;
    set_model(0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_sel", {26'd0, digit_sel}, 32'h20);
    check("reset_seg", {25'd0, seg}, 32'h40);
    load = 1'b0;
    rst  = 1'b0;
    k    = 0;
    #1;
    check("release_sel", {26'd0, digit_sel}, 32'h20);
    check("release_seg", {25'd0, seg}, 32'h40);
    check("release_busy", {31'd0, busy}, 0);
    check("release_leader", {30'd0, leader}, 0);
    idle_cycles(30);

    convert(123, 45, 0);
    convert(511, 511, 0);
    convert(0, 7, 0);
    convert(258, 300, 5);
    reset_mid_conversion();
    convert(300, 200, 0);
    for (int t = 0; t < 8; t++) begin
      convert(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              (t % 2 == 0) ? 0 : int'($urandom_range(2, 18)));
    end
    convert(99, 99, 18);
    convert(10, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
